// File: rtl/lcd_frame_ctrl.sv
// HD44780-style 16x2 LCD sequencer: power-on init, then full-frame redraws of 32
// formatter characters on request, with all bus timing counted in clk cycles.
module lcd_frame_ctrl #(
    parameter int PWR_CYC   = 750000,
    parameter int SETUP_CYC = 3,
    parameter int E_CYC     = 12,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    input  logic [7:0] char_in,
    output logic [4:0] index,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       frame_done
);
    localparam logic [19:0] PWR_M1   = 20'(PWR_CYC - 1);
    localparam logic [19:0] SETUP_M1 = 20'(SETUP_CYC - 1);
    localparam logic [19:0] E_M1     = 20'(E_CYC - 1);
    localparam logic [19:0] CMD_M1   = 20'(CMD_CYC - 1);
    localparam logic [19:0] CLR_M1   = 20'(CLR_CYC - 1);

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_IDLE, S_ADDR1, S_FETCH, S_DATA, S_ADDR2, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [19:0] cnt_q, cnt_d;
    logic [2:0]  step_q, step_d;
    logic        fetch_q, fetch_d;
    logic        pend_q, pend_d;
    logic [4:0]  index_q, index_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic [19:0] hold_m1;

    function automatic logic [7:0] init_cmd(input logic [2:0] step);
        case (step)
            3'd0, 3'd1: init_cmd = 8'h38;
            3'd2:       init_cmd = 8'h0C;
            3'd3:       init_cmd = 8'h06;
            default:    init_cmd = 8'h01;
        endcase
    endfunction

    // Only the clear command needs the long post-pulse wait.
    assign hold_m1 = (!rs_q && data_q == 8'h01) ? CLR_M1 : CMD_M1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        fetch_d = fetch_q;
        pend_d  = pend_q;
        index_d = index_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            S_PWR: begin
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == PWR_M1) begin
                    state_d = S_INIT;
                    step_d  = 3'd0;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                    rs_d    = 1'b0;
                    data_d  = init_cmd(3'd0);
                end
            end
            S_IDLE: begin
                if (pend_q) begin
                    state_d = S_ADDR1;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                    rs_d    = 1'b0;
                    data_d  = 8'h80;
                end
            end
            S_FETCH: begin
                // Cycle 0 presents index; formatter answers during cycle 1.
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    state_d = S_DATA;
                    cnt_d   = '0;
                    phase_d = PH_SETUP;
                    rs_d    = 1'b1;
                    data_d  = char_in;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                index_d = 5'd0;
                done_d  = 1'b1;
            end
            default: begin
                case (phase_q)
                    PH_SETUP: begin
                        cnt_d = cnt_q + 20'd1;
                        if (cnt_q == SETUP_M1) begin
                            phase_d = PH_PULSE;
                            e_d     = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                    PH_PULSE: begin
                        cnt_d = cnt_q + 20'd1;
                        if (cnt_q == E_M1) begin
                            phase_d = PH_HOLD;
                            e_d     = 1'b0;
                            cnt_d   = '0;
                        end
                    end
                    PH_HOLD: begin
                        cnt_d = cnt_q + 20'd1;
                        if (cnt_q == hold_m1) begin
                            cnt_d   = '0;
                            phase_d = PH_SETUP;
                            case (state_q)
                                S_INIT: begin
                                    if (step_q == 3'd4) begin
                                        state_d = S_IDLE;
                                    end else begin
                                        step_d = step_q + 3'd1;
                                        data_d = init_cmd(step_q + 3'd1);
                                    end
                                end
                                S_ADDR1: begin
                                    state_d = S_FETCH;
                                    index_d = 5'd0;
                                    fetch_d = 1'b0;
                                end
                                S_ADDR2: begin
                                    state_d = S_FETCH;
                                    index_d = 5'd16;
                                    fetch_d = 1'b0;
                                end
                                S_DATA: begin
                                    if (index_q == 5'd15) begin
                                        state_d = S_ADDR2;
                                        rs_d    = 1'b0;
                                        data_d  = 8'hC0;
                                    end else if (index_q == 5'd31) begin
                                        state_d = S_DONE;
                                    end else begin
                                        state_d = S_FETCH;
                                        index_d = index_q + 5'd1;
                                        fetch_d = 1'b0;
                                    end
                                end
                                default: state_d = S_IDLE;
                            endcase
                        end
                    end
                    default: phase_d = PH_SETUP;
                endcase
            end
        endcase
        if (refresh) pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PWR;
            phase_q <= PH_SETUP;
            cnt_q   <= '0;
            step_q  <= '0;
            fetch_q <= 1'b0;
            pend_q  <= 1'b1;
            index_q <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            fetch_q <= fetch_d;
            pend_q  <= pend_d;
            index_q <= index_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign index      = index_q;
    assign lcd_e      = e_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = data_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
endmodule
